// File: rtl/qei_decoder_core_if.sv
// Bus bundle for qei_decoder_core: control inputs, raw encoder pins and decoded outputs.
// Clock and reset stay as plain ports on the core.
`timescale 1ns/1ps

interface qei_if #(
    parameter int CNT_W = 16
);
    logic             ena;
    logic             enc_a;
    logic             enc_b;
    logic             enc_z;
    logic [1:0]       mode;
    logic             z_clear_en;
    logic             load;
    logic [CNT_W-1:0] preset_val;
    logic             clr;
    logic             err_clr;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic             step;
    logic             err;
    logic             index_seen;
    logic [CNT_W-1:0] cap_count;

    // Side that drives pins and controls and observes the position outputs.
    modport master (
        output ena, enc_a, enc_b, enc_z, mode, z_clear_en, load, preset_val, clr, err_clr,
        input  count, dir, step, err, index_seen, cap_count
    );

    // Decoder side.
    modport slave (
        input  ena, enc_a, enc_b, enc_z, mode, z_clear_en, load, preset_val, clr, err_clr,
        output count, dir, step, err, index_seen, cap_count
    );
endinterface

// File: rtl/qei_decoder_core.sv
// Parametrised quadrature encoder decoder.
// A/B/Z are synchronised, deglitched, then {A,B} transitions are decoded in
// x4/x2/x1 resolution into a wrapping position count, with index capture,
// preset load, clear, sticky illegal-transition error and a per-count step pulse.
`timescale 1ns/1ps

module qei_decoder_core #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3
) (
    input logic  clk,
    input logic  rst_n,
    qei_if.slave bus
);

    localparam int FC_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam int WU_W = $clog2(SYNC_STAGES + 1);

    localparam logic [1:0] MODE_X2 = 2'b01;
    localparam logic [1:0] MODE_X1 = 2'b10;

    // Next state going forward around 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    // Whether a legal forward step landing in cur is counted at this resolution.
    function automatic logic fwd_counts(input logic [1:0] md, input logic [1:0] cur);
        logic c;
        case (md)
            MODE_X2: c = (cur == 2'b11) || (cur == 2'b00);
            MODE_X1: c = (cur == 2'b11);
            default: c = 1'b1;
        endcase
        return c;
    endfunction

    // Whether a legal backward step landing in cur is counted at this resolution.
    function automatic logic bwd_counts(input logic [1:0] md, input logic [1:0] cur);
        logic c;
        case (md)
            MODE_X2: c = (cur == 2'b01) || (cur == 2'b10);
            MODE_X1: c = (cur == 2'b01);
            default: c = 1'b1;
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser: bit 2 = Z, bit 1 = A, bit 0 = B
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [2:0]                  sync_out;

    // Shift raw pins through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], {bus.enc_z, bus.enc_a, bus.enc_b}};
    end

    // Synchroniser registers.
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Deglitch filter: new level accepted after FILT_CYCLES equal samples
    // ------------------------------------------------------------------
    logic [2:0] filt;

    generate
        if (FILT_CYCLES == 0) begin : g_bypass
            assign filt = sync_out;
        end else begin : g_filt
            logic [2:0]           filt_q, filt_d;
            logic [2:0][FC_W-1:0] fcnt_q, fcnt_d;

            // Count consecutive samples that disagree with the accepted level.
            always_comb begin
                filt_d = filt_q;
                fcnt_d = fcnt_q;
                for (int i = 0; i < 3; i++) begin
                    if (sync_out[i] == filt_q[i]) begin
                        fcnt_d[i] = '0;
                    end else if (fcnt_q[i] == FC_W'(FILT_CYCLES - 1)) begin
                        filt_d[i] = sync_out[i];
                        fcnt_d[i] = '0;
                    end else begin
                        fcnt_d[i] = fcnt_q[i] + 1'b1;
                    end
                end
            end

            // Filter level and run-length registers.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    filt_q <= '0;
                    fcnt_q <= '0;
                end else begin
                    filt_q <= filt_d;
                    fcnt_q <= fcnt_d;
                end
            end

            assign filt = filt_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode and position datapath
    // ------------------------------------------------------------------
    logic [1:0]       ab_cur;
    logic             z_cur;
    logic             z_rise;
    logic             wu_done;
    logic             prime_now;
    logic             dec_step;
    logic             dec_fwd;
    logic             bad_move;

    logic [WU_W-1:0]  wu_q, wu_d;
    logic             primed_q, primed_d;
    logic [1:0]       prev_q, prev_d;
    logic             z_prev_q, z_prev_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] cap_q, cap_d;

    assign ab_cur  = filt[1:0];
    assign z_cur   = filt[2];
    assign z_rise  = z_cur & ~z_prev_q;
    assign wu_done = (wu_q == WU_W'(SYNC_STAGES));
    // Prime only once the synchroniser holds real pin data and the filter agrees with it,
    // so a non-zero resting level after reset is not mistaken for a transition.
    assign prime_now = ~primed_q & wu_done & (sync_out[1:0] == ab_cur);

    // Classify the filtered {A,B} change against the previous state.
    always_comb begin
        dec_step = 1'b0;
        dec_fwd  = 1'b0;
        bad_move = 1'b0;
        if (primed_q && (ab_cur != prev_q)) begin
            if (ab_cur == fwd_next(prev_q)) begin
                dec_fwd  = 1'b1;
                dec_step = fwd_counts(bus.mode, ab_cur);
            end else if (prev_q == fwd_next(ab_cur)) begin
                dec_step = bwd_counts(bus.mode, ab_cur);
            end else begin
                bad_move = 1'b1;
            end
        end
        dec_step = dec_step & bus.ena;
        bad_move = bad_move & bus.ena;
    end

    // Warm-up, priming, count priority, index capture and sticky flags.
    always_comb begin
        wu_d     = wu_done ? wu_q : wu_q + 1'b1;
        primed_d = primed_q | prime_now;
        prev_d   = (primed_q || prime_now) ? ab_cur : prev_q;
        z_prev_d = z_cur;
        count_d  = count_q;
        dir_d    = dec_step ? dec_fwd : dir_q;
        step_d   = 1'b0;
        err_d    = err_q;
        seen_d   = seen_q;
        cap_d    = cap_q;

        if (bus.load) begin
            count_d = bus.preset_val;
        end else if (bus.clr) begin
            count_d = '0;
        end else if (z_rise && bus.z_clear_en) begin
            count_d = '0;
        end else if (dec_step) begin
            count_d = dec_fwd ? count_q + 1'b1 : count_q - 1'b1;
            step_d  = 1'b1;
        end

        if (z_rise) begin
            cap_d  = count_q;
            seen_d = 1'b1;
        end else if (bus.clr) begin
            seen_d = 1'b0;
        end

        if (bad_move)         err_d = 1'b1;
        else if (bus.err_clr) err_d = 1'b0;
    end

    // Decoder state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wu_q     <= '0;
            primed_q <= 1'b0;
            prev_q   <= '0;
            z_prev_q <= 1'b0;
            count_q  <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            seen_q   <= 1'b0;
            cap_q    <= '0;
        end else begin
            wu_q     <= wu_d;
            primed_q <= primed_d;
            prev_q   <= prev_d;
            z_prev_q <= z_prev_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            err_q    <= err_d;
            seen_q   <= seen_d;
            cap_q    <= cap_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.dir        = dir_q;
    assign bus.step       = step_q;
    assign bus.err        = err_q;
    assign bus.index_seen = seen_q;
    assign bus.cap_count  = cap_q;

endmodule
